// File: rtl/data_mem_responder_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Encodes access sizes, responder states and the byte-lane mapping for little-endian stores.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } resp_state_t;

    function automatic logic [3:0] lane_enable(input mem_size_t size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data arrives LSB-aligned; copying it to every lane lets the enables pick the target lane.
    function automatic logic [31:0] replicate_wdata(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data-memory responder.
interface data_mem_responder_if;
    import data_mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word-organised data RAM with per-byte write enables, synchronous write and combinational read.
module data_mem_array #(
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1 << AW) - 1];

    // Byte-lane write; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: request capture, wait-state counter, error check,
// byte/half/word access on the data RAM and sign/zero extension of load data.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    data_mem_responder_if.slave  bus
);

    localparam int WORD_AW = ADDR_WIDTH - 2;

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    mem_size_t   size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        access_s;
    logic        size_err_s;
    logic        range_err_s;
    logic        err_s;
    logic [3:0]  be_s;
    logic [31:0] ram_rdata_s;
    logic [31:0] shifted_s;
    logic [31:0] load_s;

    assign accept_s = bus.req_valid && ready_q && (state_q == ST_IDLE);

    // Misalignment, illegal size and out-of-range decoding of the captured request.
    always_comb begin
        size_err_s = 1'b0;
        case (size_q)
            SZ_BYTE: size_err_s = 1'b0;
            SZ_HALF: size_err_s = addr_q[0];
            SZ_WORD: size_err_s = |addr_q[1:0];
            default: size_err_s = 1'b1;
        endcase
    end

    assign range_err_s = |(addr_q >> ADDR_WIDTH);
    assign err_s       = size_err_s || range_err_s;

    // Lane enables only fire on the access edge of a legal store.
    always_comb begin
        be_s = 4'b0000;
        if (access_s && we_q && !err_s) begin
            be_s = lane_enable(size_q, addr_q[1:0]);
        end else begin
            be_s = 4'b0000;
        end
    end

    data_mem_array #(
        .AW(WORD_AW)
    ) u_array (
        .clk_i   (clk_i),
        .addr_i  (addr_q[ADDR_WIDTH-1:2]),
        .be_i    (be_s),
        .wdata_i (replicate_wdata(size_q, wdata_q)),
        .rdata_o (ram_rdata_s)
    );

    assign shifted_s = ram_rdata_s >> {addr_q[1:0], 3'b000};

    // Lane extraction plus sign/zero extension of load data.
    always_comb begin
        load_s = 32'd0;
        case (size_q)
            SZ_BYTE: load_s = uns_q ? {24'd0, shifted_s[7:0]}
                                    : {{24{shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: load_s = uns_q ? {16'd0, shifted_s[15:0]}
                                    : {{16{shifted_s[15]}}, shifted_s[15:0]};
            SZ_WORD: load_s = ram_rdata_s;
            default: load_s = 32'd0;
        endcase
    end

    // Next-state, counter and response-data logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        access_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access_s = 1'b1;
                    state_d  = ST_RESP;
                    rdata_d  = (err_s || we_q) ? 32'd0 : load_s;
                    err_d    = err_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields are frozen at the accept edge so later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept_s) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model, per-cycle output compare and directed
// load/store sequences, plus a zero-wait-state instance for the minimum-latency case.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if busz ();

    data_mem_responder #(.ADDR_WIDTH(17), .WAIT_CYCLES(W)) dut (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus)
    );
    data_mem_responder #(.ADDR_WIDTH(17), .WAIT_CYCLES(0)) dutz (
        .clk_i (clk), .rst_ni (rst_n), .bus (busz)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nbytes;
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          since_rst = 0;
    int          last_pop = 0;
    int          last_acc = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    logic [7:0]  mem_m [int];
    exp_t        q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input mem_size_t s);
        case (s)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            SZ_WORD: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_err(input mem_size_t s, input logic [31:0] addr);
        int n;
        n = nbytes_of(s);
        if (n == 0) return 1'b1;
        if (addr >= 32'h0002_0000) return 1'b1;
        return (addr % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input mem_size_t s, input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        n = nbytes_of(s);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, mem_m[int'(addr) + i]} << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) since_rst = 0;
        else since_rst = since_rst + 1;
    end

    // Per-cycle compare against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        end else if (q.size() != 0 && (cyc - q[0].acc) >= 1 + W) begin
            chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, q[0].err});
            chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            if (bus.rsp_ready) begin
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                last_pop   = cyc;
                if (q[0].we && !q[0].err) begin
                    for (int i = 0; i < q[0].nbytes; i++)
                        mem_m[int'(q[0].addr) + i] = q[0].wdata[8*i +: 8];
                end
                void'(q.pop_front());
            end
        end else begin
            chk("rsp_valid_low", {31'd0, bus.rsp_valid}, 32'd0);
            chk("req_ready", {31'd0, bus.req_ready},
                (since_rst == 0 || q.size() != 0) ? 32'd0 : 32'd1);
        end
    end

    task automatic issue(input logic we, input mem_size_t sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int t;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req_ready && t < 60);
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wd;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wd;
        e.nbytes = nbytes_of(sz);
        e.err    = model_err(sz, addr);
        e.rdata  = (e.err || we) ? 32'd0 : model_load(sz, uns, addr);
        e.acc    = cyc;
        last_acc = cyc;
        q.push_back(e);
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        while (q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("response_timeout", 32'd0, 32'd1);
            q.delete();
        end
        #1;
    endtask

    task automatic do_req(input logic we, input mem_size_t sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        issue(we, sz, uns, addr, wd);
        wait_rsp();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
        busz.req_valid = 1'b0; busz.req_we = 1'b0; busz.req_size = SZ_WORD; busz.req_unsigned = 1'b0;
        busz.req_addr = 32'd0; busz.req_wdata = 32'd0; busz.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h1122_3344);
        chk("sw_rdata", last_rdata, 32'd0);

        // Reset in the middle of the wait period must drop the store.
        issue(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0);
        chk("t1_lw_after_rst", last_rdata, 32'h1122_3344);

        do_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h1234_5678);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
        chk("t2_lw", last_rdata, 32'h1234_5678);
        chk("t2_err", {31'd0, last_err}, 32'd0);

        do_req(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'hCCDD_EEAA);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
        chk("t3_lw", last_rdata, 32'h1234_AA78);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h41, 32'd0);
        chk("t3_lb", last_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h41, 32'd0);
        chk("t3_lbu", last_rdata, 32'h0000_00AA);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h42, 32'd0);
        chk("t3_lh", last_rdata, 32'h0000_1234);

        do_req(1'b1, SZ_HALF, 1'b0, 32'h46, 32'h5555_BEEF);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h46, 32'd0);
        chk("lh_neg", last_rdata, 32'hFFFF_BEEF);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h46, 32'd0);
        chk("lhu", last_rdata, 32'h0000_BEEF);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h47, 32'd0);
        chk("lb_lane3", last_rdata, 32'hFFFF_FFBE);

        do_req(1'b0, SZ_WORD, 1'b0, 32'h42, 32'd0);
        chk("t4_lw_mis_err", {31'd0, last_err}, 32'd1);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h43, 32'h9999);
        chk("t4_sh_mis_err", {31'd0, last_err}, 32'd1);
        do_req(1'b0, SZ_ILL, 1'b0, 32'h40, 32'd0);
        chk("t4_ill_err", {31'd0, last_err}, 32'd1);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0002_0000, 32'd0);
        chk("t4_range_err", {31'd0, last_err}, 32'd1);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h0002_0040, 32'hFFFF_FFFF);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
        chk("t4_ram_unchanged", last_rdata, 32'h1234_AA78);

        // Response back-pressure with a second request already waiting.
        bus.rsp_ready = 1'b0;
        issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
        fork
            issue(1'b0, SZ_BYTE, 1'b1, 32'h41, 32'd0);
            begin
                repeat (1 + W + 5) @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        chk("t5_second_accept", 32'(last_acc - last_pop), 32'd2);
        wait_rsp();
        chk("t5_lbu", last_rdata, 32'h0000_00AA);

        // Zero wait-state instance: response after the edge following accept.
        busz.req_valid = 1'b1; busz.req_we = 1'b1; busz.req_size = SZ_WORD;
        busz.req_addr = 32'h8; busz.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t6_ready", {31'd0, busz.req_ready}, 32'd1);
        chk("t6_idle_valid", {31'd0, busz.rsp_valid}, 32'd0);
        @(posedge clk);
        #1 busz.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_sw_valid", {31'd0, busz.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t6_sw_valid_n1", {31'd0, busz.rsp_valid}, 32'd1);
        chk("t6_sw_err", {31'd0, busz.rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        busz.req_valid = 1'b1; busz.req_we = 1'b0;
        @(negedge clk);
        chk("t6_ready2", {31'd0, busz.req_ready}, 32'd1);
        @(posedge clk);
        #1 busz.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_lw_valid_n0", {31'd0, busz.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t6_lw_valid_n1", {31'd0, busz.rsp_valid}, 32'd1);
        chk("t6_lw_rdata", busz.rsp_rdata, 32'hCAFE_F00D);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
